// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on the operand and result sides.
module bcd_convert_ctrl #(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [WIDTH-1:0]      BINARY,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  BUSY
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p = 64'd1;
        for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam longint unsigned MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_check
            $error("bcd_convert_ctrl: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [WIDTH-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   bcd_sr;
    logic [4*DIGITS-1:0]   bcd_step;
    logic [4*DIGITS-1:0]   bcd_q;
    logic [CNT_W-1:0]      cnt;
    logic                  last_step;
    logic [3:0]            top_dig;
    logic [2:0]            top_adj;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (IN_VALID)  state_next = CONV;
            CONV:    if (last_step) state_next = HOLD;
            HOLD:    if (OUT_READY) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Top digit's adjusted bit 3 is shifted out; the DIGITS rule keeps it zero,
    // so only its low three bits are carried into the shifted result.
    assign top_dig = bcd_sr[4*DIGITS-1 -: 4];
    assign top_adj = (top_dig >= 4'd5) ? top_dig[2:0] + 3'd3 : top_dig[2:0];

    always_comb begin
        bcd_step = '0;
        for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
            bcd_step[4*k+1 +: 4] = (bcd_sr[4*k +: 4] >= 4'd5)
                                 ? bcd_sr[4*k +: 4] + 4'd3
                                 : bcd_sr[4*k +: 4];
        end
        bcd_step[4*DIGITS-1 -: 3] = top_adj;
        bcd_step[0]               = bin_sr[WIDTH-1];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            bcd_q  <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        bin_sr <= BINARY;
                        bcd_sr <= '0;
                        cnt    <= '0;
                    end
                end
                CONV: begin
                    bcd_sr <= bcd_step;
                    bin_sr <= bin_sr << 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) bcd_q <= bcd_step;
                end
                default: ;
            endcase
        end
    end

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == HOLD);
    assign BUSY      = (state == CONV);
    assign BCD       = bcd_q;

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed and random checks of bcd_convert_ctrl using a queue of expected
// BCD results pushed on accept and popped on completion.
module tb_bcd_convert_ctrl;

    localparam int WIDTH  = 9;
    localparam int DIGITS = 3;

    // {BUSY, OUT_VALID, IN_READY}
    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_CONV = 3'b100;
    localparam logic [2:0] ST_HOLD = 3'b010;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic [WIDTH-1:0]    BINARY = '0;
    logic                IN_VALID = 1'b0;
    logic                IN_READY;
    logic [4*DIGITS-1:0] BCD;
    logic                OUT_VALID;
    logic                OUT_READY = 1'b0;
    logic                BUSY;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    bcd_convert_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .BINARY(BINARY),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .BCD(BCD),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] to_bcd(input int unsigned v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] flags();
        return {BUSY, OUT_VALID, IN_READY};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pop_check(input string tag, output logic [11:0] e);
        if (exp_q.size() == 0) begin
            e = '0;
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(BCD), 32'(e));
        end
    endtask

    task automatic accept(input logic [WIDTH-1:0] v);
        int unsigned n = 0;
        while (IN_READY !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(IN_READY), 32'd1);
        BINARY   = v;
        IN_VALID = 1'b1;
        exp_q.push_back(to_bcd(v));
        tick();
        IN_VALID = 1'b0;
        chk("accept_flags", 32'(flags()), 32'(ST_CONV));
    endtask

    task automatic convert(input logic [WIDTH-1:0] v, input int unsigned inject_at,
                           input int unsigned stall);
        logic [11:0] e;
        accept(v);
        for (int unsigned i = 1; i <= 9; i++) begin
            if (i == inject_at) begin
                BINARY   = 9'd77;
                IN_VALID = 1'b1;
            end
            tick();
            IN_VALID = 1'b0;
            chk("latency_flags", 32'(flags()), 32'((i < 9) ? ST_CONV : ST_HOLD));
        end
        pop_check("bcd_result", e);
        for (int unsigned s = 0; s < stall; s++) begin
            if (s == 5) begin
                BINARY   = 9'd123;
                IN_VALID = 1'b1;
            end
            tick();
            IN_VALID = 1'b0;
            chk("hold_flags", 32'(flags()), 32'(ST_HOLD));
            chk("hold_bcd", 32'(BCD), 32'(e));
        end
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
        chk("release_flags", 32'(flags()), 32'(ST_IDLE));
    endtask

    initial begin
        logic [11:0] e;
        logic [WIDTH-1:0] rv;
        int sum;

        tick();
        tick();
        chk("reset_flags", 32'(flags()), 32'(ST_IDLE));
        chk("reset_bcd", 32'(BCD), 32'd0);
        RST_N = 1'b1;
        tick();

        convert(9'd0,   0, 0);
        convert(9'd511, 0, 0);
        convert(9'd255, 0, 0);
        convert(9'd100, 0, 0);
        convert(9'd9,   0, 0);

        convert(9'd347, 0, 20);

        convert(9'd200, 4, 0);

        // Reset at cnt == 5 of a conversion discards the partial result.
        accept(9'd400);
        repeat (5) tick();
        RST_N = 1'b0;
        #1;
        chk("mid_reset_flags", 32'(flags()), 32'(ST_IDLE));
        chk("mid_reset_bcd", 32'(BCD), 32'd0);
        exp_q.delete();
        tick();
        tick();
        RST_N = 1'b1;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            chk("post_reset_no_valid", 32'(OUT_VALID), 32'd0);
        end
        chk("post_reset_bcd", 32'(BCD), 32'd0);

        // Back-to-back with IN_VALID and OUT_READY held high.
        BINARY    = 9'd1;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        exp_q.push_back(to_bcd(1));
        chk("b2b_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("b2b_accept", 32'(flags()), 32'(ST_CONV));
        for (int unsigned v = 1; v <= 3; v++) begin
            for (int unsigned i = 1; i <= 11; i++) begin
                tick();
                if (i == 9) begin
                    pop_check("b2b_bcd", e);
                    if (v < 3) begin
                        BINARY = 9'(v + 1);
                        exp_q.push_back(to_bcd(v + 1));
                    end else begin
                        IN_VALID = 1'b0;
                    end
                end
                chk("b2b_flags", 32'(flags()),
                    32'((i < 9)   ? ST_CONV :
                        (i == 9)  ? ST_HOLD :
                        (i == 10) ? ST_IDLE :
                        (v < 3)   ? ST_CONV : ST_IDLE));
            end
        end
        OUT_READY = 1'b0;
        IN_VALID  = 1'b0;

        for (int unsigned n = 0; n < 30; n++) begin
            rv = 9'($urandom) & 9'h1FF;
            convert(rv, 0, n % 3);
            sum = int'(BCD[11:8]) * 100 + int'(BCD[7:4]) * 10 + int'(BCD[3:0]);
            chk("rand_sum", 32'(sum), 32'(rv));
            chk("rand_digits",
                32'((BCD[11:8] <= 4'd9) && (BCD[7:4] <= 4'd9) && (BCD[3:0] <= 4'd9)),
                32'd1);
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
